// File: rtl/reg_bcd_converter_pkg.sv
// Shared definitions for the register-to-BCD converter: default sizes,
// FSM encoding and the BCD saturation digit.
package reg_bcd_converter_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DIGITS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Saturated display output is built by repeating this digit.
    localparam logic [3:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/reg_bcd_converter_bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/reg_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that
// feeds the display controller; saturates to all-nines on overflow.
module reg_bcd_converter
    import reg_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(WIDTH + 1);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        scratch, scratch_adj;
    logic [WIDTH-1:0]     operand;
    logic [SW+WIDTH-1:0]  shifted;
    logic                 load, shift_en, finish;

    function automatic logic [4*DIGITS-1:0] sat_bcd(input logic [SW-1:0] s);
        if (s[SW-1 -: 4] != 4'd0)
            return {DIGITS{BCD_NINE}};
        return s[4*DIGITS-1:0];
    endfunction

    for (genvar d = 0; d < DIGITS + 1; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*d +: 4]),
            .dout (scratch_adj[4*d +: 4])
        );
    end

    assign shifted = {scratch_adj, operand} << 1;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CW'(1))
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                finish    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            scratch <= '0;
            bcd     <= '0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state <= state_nxt;
            valid <= finish;
            if (load) begin
                cnt     <= CW'(WIDTH);
                scratch <= '0;
            end else if (shift_en) begin
                cnt     <= cnt - CW'(1);
                scratch <= shifted[SW+WIDTH-1:WIDTH];
            end
            if (finish) begin
                bcd <= sat_bcd(scratch);
                ovf <= (scratch[SW-1 -: 4] != 4'd0);
            end
        end
    end

    // Operand is pure data and only ever loaded before being consumed.
    always_ff @(posedge clk) begin
        if (load)
            operand <= bin_in;
        else if (shift_en)
            operand <= shifted[WIDTH-1:0];
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_SHIFT) || (state == ST_DONE);

endmodule

// File: tb/tb_reg_bcd_converter.sv
// Scoreboard bench for reg_bcd_converter: stimulus pushes hand-computed
// results, an independent monitor checks every valid pulse.
module tb_reg_bcd_converter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        ready, busy, valid, ovf;
    logic [15:0] bcd;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    reg_bcd_converter #(.WIDTH(16), .DIGITS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bin_in (bin_in),
        .ready  (ready),
        .busy   (busy),
        .valid  (valid),
        .bcd    (bcd),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset && valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got bcd=%0h with no request pending, expected none", bcd);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bcd", 32'(bcd), 32'(e.bcd));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                chk("ready_with_valid", 32'(ready), 32'd1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got ready=0, expected 1");
        end
    endtask

    task automatic convert(input logic [15:0] v, input logic [15:0] eb, input logic eo);
        wait_ready();
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = ~v;
        q.push_back('{eb, eo, cyc + 17});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #2;
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        convert(16'd1234,  16'h1234, 1'b0);
        convert(16'd0,     16'h0000, 1'b0);
        convert(16'd9999,  16'h9999, 1'b0);
        convert(16'd10000, 16'h9999, 1'b1);
        convert(16'd65535, 16'h9999, 1'b1);
        convert(16'd100,   16'h0100, 1'b0);
        drain();

        // Outputs hold between pulses.
        repeat (5) @(negedge clk);
        chk("hold_bcd", 32'(bcd), 32'h0100);
        chk("hold_ovf", 32'(ovf), 32'h0);

        // A start during busy must be ignored.
        convert(16'd42, 16'h0042, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_mid", 32'(busy), 32'h1);
        start  = 1'b1;
        bin_in = 16'd999;
        @(posedge clk);
        #1;
        start  = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("no_extra_valid_bcd", 32'(bcd), 32'h0042);

        // Reset in the middle of a conversion aborts it.
        wait_ready();
        start  = 1'b1;
        bin_in = 16'd5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_bcd", 32'(bcd), 32'h0);
        chk("abort_ovf", 32'(ovf), 32'h0);
        chk("abort_valid", 32'(valid), 32'h0);
        chk("abort_ready", 32'(ready), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'h1);
        chk("post_rst_busy", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        chk("abort_no_result", 32'(bcd), 32'h0);
        convert(16'd7, 16'h0007, 1'b0);
        drain();

        // Start held high: back-to-back conversions 18 cycles apart.
        wait_ready();
        start  = 1'b1;
        bin_in = 16'd12;
        @(posedge clk);
        #1;
        q.push_back('{16'h0012, 1'b0, cyc + 17});
        q.push_back('{16'h0345, 1'b0, cyc + 18 + 17});
        bin_in = 16'd345;
        repeat (18) @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'h1);
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
